// File: rtl/mux_gate_selftest.sv
// On-chip self-test: sweeps {a,b} over 00..11, samples the six gate outputs, scores them against a truth table.
// Latency: done rises 4*(SETTLE_CYCLES+1) cycles after the accepting start edge.
// Backpressure: none; start is ignored while busy, and a start in DONE restarts immediately.
module mux_gate_selftest #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    input  logic       and_in,
    input  logic       or_in,
    input  logic       nand_in,
    input  logic       nor_in,
    input  logic       xor_in,
    input  logic       xnor_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [5:0] fail_mask,
    output logic [3:0] fail_vec
);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    localparam logic [3:0] LAST_SETTLE = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [1:0] vec;
    logic [3:0] settle_cnt;

    logic [5:0] exp_bits;
    logic [5:0] act_bits;
    logic [5:0] mis;
    logic [2:0] mis_cnt;
    logic [4:0] err_next;

    // Expected values come from the registered drive, so they are stable across the whole CHECK cycle.
    always_comb begin
        exp_bits = {~(a_out ^ b_out), a_out ^ b_out, ~(a_out | b_out),
                    ~(a_out & b_out), a_out | b_out, a_out & b_out};
        act_bits = {xnor_in, xor_in, nor_in, nand_in, or_in, and_in};
        mis      = exp_bits ^ act_bits;
        mis_cnt  = 3'd0;
        for (int i = 0; i < 6; i++) begin
            mis_cnt = mis_cnt + {2'b00, mis[i]};
        end
        err_next = err_count + {2'b00, mis_cnt};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            vec        <= 2'd0;
            settle_cnt <= 4'd0;
            a_out      <= 1'b0;
            b_out      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 5'd0;
            fail_mask  <= 6'd0;
            fail_vec   <= 4'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= SETTLE;
                        vec         <= 2'd0;
                        settle_cnt  <= 4'd0;
                        {a_out, b_out} <= 2'b00;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        err_count   <= 5'd0;
                        fail_mask   <= 6'd0;
                        fail_vec    <= 4'd0;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + 4'd1;
                    if (settle_cnt == LAST_SETTLE) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    err_count     <= err_next;
                    fail_mask     <= fail_mask | mis;
                    fail_vec[vec] <= fail_vec[vec] | (|mis);
                    if (vec == 2'd3) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == 5'd0);
                    end else begin
                        state          <= SETTLE;
                        vec            <= vec + 2'd1;
                        {a_out, b_out} <= vec + 2'd1;
                        settle_cnt     <= 4'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mux_gate_selftest.md
Name: mux_gate_selftest

Overview:
- Sequential stimulus-and-check stage wrapped around the mux-based logic-gate block (inputs a, b; outputs and/or/nand/nor/xor/xnor).
- On start, drives all four (a,b) combinations into the gate block, waits a settle interval per vector, then samples the six gate outputs against an internal truth table.
- Reports pass/fail, a mismatch count, and per-gate and per-vector failure masks.
- Replaces the free-running testbench sequence with a synthesizable, on-chip self-test.

Parameters:
- SETTLE_CYCLES, 2, clock cycles each vector is held before sampling; legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to run a full sweep; accepted only in IDLE or DONE
- a_out  output  1  drives gate block input a
- b_out  output  1  drives gate block input b
- and_in  input  1  gate block AND result
- or_in  input  1  gate block OR result
- nand_in  input  1  gate block NAND result
- nor_in  input  1  gate block NOR result
- xor_in  input  1  gate block XOR result
- xnor_in  input  1  gate block XNOR result
- busy  output  1  high while a sweep is in progress
- done  output  1  high from sweep completion until next accepted start or reset
- pass  output  1  valid when done=1; 1 iff err_count==0
- err_count  output  5  total mismatching output bits across the sweep, 0..24
- fail_mask  output  6  sticky per-gate failure; bit order [0]and [1]or [2]nand [3]nor [4]xor [5]xnor
- fail_vec  output  4  sticky per-vector failure; bit i set if vector i ({a,b}=i) had any mismatch

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; a_out=0, b_out=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, fail_vec=0, vector index=0, settle counter=0.
- Reset has priority over start and applies mid-sweep: the sweep is aborted with no partial result retained.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE/DONE + start=1:
  - Clear err_count, fail_mask, fail_vec, done, pass.
  - Set vec=0, {a_out,b_out}=2'b00, counter=0, busy=1.
  - Go to SETTLE.
- SETTLE: counter increments each cycle; when counter==SETTLE_CYCLES-1, go to CHECK. a_out and b_out are held stable throughout.
- CHECK (exactly one cycle):
  - Expected values: and=a&b, or=a|b, nand=~(a&b), nor=~(a|b), xor=a^b, xnor=~(a^b), computed from the registered a_out and b_out.
  - m = expected XOR actual (6 bits).
  - At the clock edge: err_count += popcount(m); fail_mask |= m; fail_vec[vec] |= (|m).
  - If vec==3: go to DONE (busy=0, done=1, pass=(final err_count==0)).
  - Otherwise: vec++, {a_out,b_out}=vec+1, counter=0, go to SETTLE.
- Vector order: {a,b} = 00, 01, 10, 11.
- Latency: the edge accepting start is edge 0; done rises at edge 4*(SETTLE_CYCLES+1). With the default (2), that is 12 cycles.
- start while busy=1 is ignored, with no effect on the sweep.
- start in DONE restarts immediately; results are cleared at that edge.
- start held high continuously: a new sweep is accepted on the edge after each completion, so done is high for one cycle only.
- Gate inputs are sampled only in CHECK. Glitches during SETTLE do not count.
- err_count cannot overflow: 5 bits covers the maximum of 24.

Test Plan:
- Correct gate block, default parameter, start pulse → a/b sequence 00,01,10,11 with each vector held 3 cycles; done=1 at cycle 12; pass=1, err_count=0, fail_mask=6'h00, fail_vec=4'h0.
- Faulty gate block with xor stuck at 0 → err_count=2, fail_mask=6'b010000, fail_vec=4'b0110, pass=0.
- All six outputs inverted → err_count=24, fail_mask=6'h3F, fail_vec=4'hF, pass=0.
- start re-pulsed at cycle 5 of a sweep → ignored; done still at cycle 12 with unchanged results. Then start in DONE → done=0 and err_count=0 on the next cycle, and a new sweep runs.
- rst asserted at cycle 7 mid-sweep → on the next edge all outputs are 0 and state is IDLE; a subsequent start completes normally.
- SETTLE_CYCLES=1 with a correct gate block → each vector held 2 cycles; done at cycle 8; pass=1.
